mem_stage_data_mem: RTL and testbench
=====================================

Name: mem_stage_data_mem

Overview:
- Data-memory responder for the MEM stage.
- Accepts the load/store request carried into the MEM stage and performs it on an internal word-addressed array with a fixed number of wait states.
- Returns the loaded word on Mem_read_value, which feeds Mem_read_value_in of the MEM/WB pipeline register.
- Drives stall to freeze the upstream pipeline while an access is in flight.

Parameters:
- DEPTH, 64: number of 32-bit words in the array; power of two, 2..4096.
- BASE_ADDR, 1024: byte address mapped to word index 0.
- WAIT_CYCLES, 4: cycles spent in BUSY per access; must be 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low; rst=0 resets immediately.
- MEM_R_EN  in  1  load request.
- MEM_W_EN  in  1  store request.
- ALU_result  in  32  byte address.
- Val_Rm  in  32  store data.
- Mem_read_value  out  32  last loaded word.
- ready  out  1  one-cycle completion pulse.
- stall  out  1  freeze for the upstream pipeline registers.

Behaviour:
- Reset values: state=IDLE, cnt=0, Mem_read_value=0, ready=0, latched op/addr/data=0. The memory array is not reset.
- Index: idx = ((ALU_result - BASE_ADDR) >> 2), truncated to log2(DEPTH) bits. Address bits [1:0] are ignored.
- stall = (MEM_R_EN | MEM_W_EN) & ~ready. This path is combinational.
- ready is registered and is high only in state DONE.
- FSM:
  - IDLE: if MEM_R_EN or MEM_W_EN is sampled high, latch op, idx and Val_Rm, load cnt = WAIT_CYCLES-1, and go to BUSY. Otherwise stay in IDLE.
  - BUSY: if cnt != 0, decrement cnt. If cnt == 0, commit the access and go to DONE.
    - Read commit: Mem_read_value <= mem[idx].
    - Write commit: mem[idx] <= data.
  - DONE: ready=1 and stall=0. Next state is always IDLE. A request still asserted in DONE is not restarted; it is treated as consumed as the pipeline advances on this edge.
- Latency: request first visible in cycle 0. stall is high in cycles 0..WAIT_CYCLES and ready is high in cycle WAIT_CYCLES+1. Each access therefore costs WAIT_CYCLES+2 cycles.
- Both MEM_R_EN and MEM_W_EN high: the access is treated as a read; the write is ignored.
- Request deasserted while in BUSY (flush): the latched access still completes and commits, and ready still pulses. stall follows its equation, so it is low while no request is present.
- Mem_read_value is unchanged by writes. It holds its value until the next read commit.
- Address wrap: addresses beyond BASE_ADDR+4*DEPTH-1, or below BASE_ADDR, alias modulo DEPTH.
- Reset asserted mid-operation: FSM returns to IDLE and the uncommitted access is dropped. No array write occurs unless it was already committed on a prior edge.
- Back-to-back requests: a new request sampled in the IDLE cycle after DONE starts a new access immediately.

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- Defined:
  - Adds output addr_err (1 bit, reset 0).
  - An access with ALU_result < BASE_ADDR, ALU_result >= BASE_ADDR+4*DEPTH, or ALU_result[1:0] != 0 goes through the same FSM timing.
  - At commit such an access suppresses the write, or sets Mem_read_value=0 for a read.
  - addr_err is high in DONE together with ready.
- Undefined: no addr_err port; wrap-around aliasing applies as above.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-activity -> Mem_read_value=0, ready=0, stall=0 with no request present; the FSM is in IDLE after release.
- Store/load, WAIT_CYCLES=4: store 0xDEADBEEF to 1032 -> stall high 5 cycles, ready pulse in cycle 5. Then load 1032 -> ready in cycle 5 and Mem_read_value=0xDEADBEEF from that cycle on.
- Wrap (macro off): store 0x12345678 to 1024+4*64=1280, then load 1024 -> 0x12345678.
- Reset mid-write: store 0xCAFEF00D to 1040 (1040 previously holds 0x0BADF00D) and assert rst in cycle 2 of BUSY -> a later load of 1040 returns 0x0BADF00D.
- Flush during BUSY: load request dropped after cycle 1 -> stall low from cycle 2; ready still pulses in cycle 5; Mem_read_value is updated.
- Range check (macro on): load 1020 -> addr_err=1 with ready in cycle 5, Mem_read_value=0. Store to 1026 -> no array change and addr_err=1.

Source files
------------

// File: rtl/mem_stage_data_mem_if.sv
// Request/response bundle between the MEM stage and its data memory.
// With MEM_RANGE_CHECK_EN defined the bundle also carries addr_err.
interface mem_stage_data_mem_if;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] ALU_result;
   logic [31:0] Val_Rm;
   logic [31:0] Mem_read_value;
   logic        ready;
   logic        stall;
`ifdef MEM_RANGE_CHECK_EN
   logic        addr_err;

   modport master (
      output MEM_R_EN, MEM_W_EN, ALU_result, Val_Rm,
      input  Mem_read_value, ready, stall, addr_err
   );
   modport slave (
      input  MEM_R_EN, MEM_W_EN, ALU_result, Val_Rm,
      output Mem_read_value, ready, stall, addr_err
   );
`else
   modport master (
      output MEM_R_EN, MEM_W_EN, ALU_result, Val_Rm,
      input  Mem_read_value, ready, stall
   );
   modport slave (
      input  MEM_R_EN, MEM_W_EN, ALU_result, Val_Rm,
      output Mem_read_value, ready, stall
   );
`endif
endinterface

// File: rtl/mem_stage_data_mem.sv
// MEM-stage data memory: fixed wait-state load/store engine with pipeline stall.
// Optional MEM_RANGE_CHECK_EN adds out-of-range/misaligned detection (addr_err).
module mem_stage_data_mem #(
   parameter int DEPTH       = 64,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   mem_stage_data_mem_if.slave        bus
);
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state_reg, state_next;
   logic [3:0]         cnt_reg, cnt_next;
   logic               op_rd_reg;
   logic [IDX_W-1:0]   idx_reg;
   logic [31:0]        data_reg;
   logic [31:0]        rd_value_reg;
   logic               ready_reg;
   logic               commit;
   logic               req;
   logic [31:0]        offset;
   logic [IDX_W-1:0]   idx_in;
   logic               unused_addr_bits;

   logic [31:0]        mem [DEPTH];

   assign req    = bus.MEM_R_EN | bus.MEM_W_EN;
   // Subtracting the base and truncating gives modulo-DEPTH aliasing for free.
   assign offset = bus.ALU_result - 32'(BASE_ADDR);
   assign idx_in = offset[IDX_W+1:2];
   assign unused_addr_bits = ^{offset[31:IDX_W+2], offset[1:0]};

`ifdef MEM_RANGE_CHECK_EN
   localparam logic [31:0] LO_ADDR = 32'(BASE_ADDR);
   localparam logic [31:0] HI_ADDR = 32'(BASE_ADDR + 4 * DEPTH);

   logic err_in;
   logic err_reg;
   logic addr_err_reg;

   assign err_in = (bus.ALU_result < LO_ADDR) || (bus.ALU_result >= HI_ADDR) ||
                   (bus.ALU_result[1:0] != 2'b00);
   assign bus.addr_err = addr_err_reg;
`endif

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      commit     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req) begin
               state_next = BUSY;
               cnt_next   = 4'(WAIT_CYCLES - 1);
            end
         end
         BUSY: begin
            if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
            end else begin
               commit     = 1'b1;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= 4'd0;
         op_rd_reg    <= 1'b0;
         idx_reg      <= '0;
         data_reg     <= 32'd0;
         rd_value_reg <= 32'd0;
         ready_reg    <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
         err_reg      <= 1'b0;
         addr_err_reg <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         ready_reg <= (state_next == DONE);
         if (state_reg == IDLE && req) begin
            // A simultaneous read and write request is executed as a read.
            op_rd_reg <= bus.MEM_R_EN;
            idx_reg   <= idx_in;
            data_reg  <= bus.Val_Rm;
`ifdef MEM_RANGE_CHECK_EN
            err_reg   <= err_in;
`endif
         end
`ifdef MEM_RANGE_CHECK_EN
         addr_err_reg <= commit & err_reg;
         if (commit && op_rd_reg) begin
            rd_value_reg <= err_reg ? 32'd0 : mem[idx_reg];
         end
`else
         if (commit && op_rd_reg) begin
            rd_value_reg <= mem[idx_reg];
         end
`endif
      end
   end

   // Array is not reset; reset forces state_reg to IDLE, which blocks commit.
   always_ff @(posedge clk) begin
`ifdef MEM_RANGE_CHECK_EN
      if (commit && !op_rd_reg && !err_reg) begin
         mem[idx_reg] <= data_reg;
      end
`else
      if (commit && !op_rd_reg) begin
         mem[idx_reg] <= data_reg;
      end
`endif
   end

   assign bus.Mem_read_value = rd_value_reg;
   assign bus.ready          = ready_reg;
   assign bus.stall          = req & ~ready_reg;

endmodule

// File: tb/tb_mem_stage_data_mem.sv
// Directed bench for mem_stage_data_mem: vector table plus reset/flush sequences.
// Define MEM_RANGE_CHECK_EN to exercise the range-check build.
module tb_mem_stage_data_mem;
   localparam int W = 4;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   mem_stage_data_mem_if bus();

   mem_stage_data_mem #(
      .DEPTH       (64),
      .BASE_ADDR   (1024),
      .WAIT_CYCLES (W)
   ) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_mrv;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] exp_mrv, input logic exp_err);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.data = data;
      v.exp_mrv = exp_mrv; v.exp_err = exp_err;
      vecs.push_back(v);
   endtask

   // Called #1 after a posedge; returns #1 after the edge that ends DONE.
   // drop_after >= 0 withdraws the request after that cycle (flush).
   task automatic run_access(input vec_t v, input int drop_after);
      logic req_on;
      bus.MEM_R_EN   = v.rd;
      bus.MEM_W_EN   = v.wr;
      bus.ALU_result = v.addr;
      bus.Val_Rm     = v.data;
      req_on = 1'b1;
      for (int c = 0; c <= W + 1; c++) begin
         if (drop_after >= 0 && c == drop_after + 1) begin
            bus.MEM_R_EN = 1'b0;
            bus.MEM_W_EN = 1'b0;
            req_on = 1'b0;
         end
         @(negedge clk);
         check($sformatf("stall c%0d", c), {31'd0, bus.stall}, {31'd0, req_on && (c <= W)});
         check($sformatf("ready c%0d", c), {31'd0, bus.ready}, {31'd0, c == W + 1});
         if (c == W + 1) begin
            check("mem_read_value", bus.Mem_read_value, v.exp_mrv);
`ifdef MEM_RANGE_CHECK_EN
            check("addr_err", {31'd0, bus.addr_err}, {31'd0, v.exp_err});
`endif
         end
         @(posedge clk);
         #1;
      end
      bus.MEM_R_EN = 1'b0;
      bus.MEM_W_EN = 1'b0;
      $display("access rd=%0b wr=%0b addr=%0d data=0x%08h mrv=0x%08h exp=0x%08h",
               v.rd, v.wr, v.addr, v.data, bus.Mem_read_value, v.exp_mrv);
   endtask

   initial begin
      vec_t v;
      total = 0;
      bad   = 0;

      add(0, 1, 32'd1032, 32'hDEADBEEF, 32'h00000000, 0);
      add(1, 0, 32'd1032, 32'h0,        32'hDEADBEEF, 0);
      add(0, 1, 32'd1040, 32'h0BADF00D, 32'hDEADBEEF, 0);
      add(1, 0, 32'd1040, 32'h0,        32'h0BADF00D, 0);
      add(0, 1, 32'd1036, 32'hA5A5A5A5, 32'h0BADF00D, 0);
      add(1, 1, 32'd1036, 32'h11111111, 32'hA5A5A5A5, 0);
      add(1, 0, 32'd1036, 32'h0,        32'hA5A5A5A5, 0);
`ifdef MEM_RANGE_CHECK_EN
      add(0, 1, 32'd1024, 32'h12345678, 32'hA5A5A5A5, 0);
      add(1, 0, 32'd1024, 32'h0,        32'h12345678, 0);
      add(1, 0, 32'd1020, 32'h0,        32'h00000000, 1);
      add(0, 1, 32'd1026, 32'h99999999, 32'h00000000, 1);
      add(1, 0, 32'd1024, 32'h0,        32'h12345678, 0);
      add(0, 1, 32'd1280, 32'h55555555, 32'h12345678, 1);
      add(1, 0, 32'd1024, 32'h0,        32'h12345678, 0);
`else
      add(1, 0, 32'd1041, 32'h0,        32'h0BADF00D, 0);
      add(0, 1, 32'd1280, 32'h12345678, 32'h0BADF00D, 0);
      add(1, 0, 32'd1024, 32'h0,        32'h12345678, 0);
      add(0, 1, 32'd1020, 32'h77777777, 32'h12345678, 0);
      add(1, 0, 32'd1276, 32'h0,        32'h77777777, 0);
`endif

      rst_n          = 1'b0;
      bus.MEM_R_EN   = 1'b0;
      bus.MEM_W_EN   = 1'b0;
      bus.ALU_result = 32'd0;
      bus.Val_Rm     = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset mrv",   bus.Mem_read_value, 32'd0);
      check("reset ready", {31'd0, bus.ready}, 32'd0);
      check("reset stall", {31'd0, bus.stall}, 32'd0);
`ifdef MEM_RANGE_CHECK_EN
      check("reset addr_err", {31'd0, bus.addr_err}, 32'd0);
`endif
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) run_access(vecs[i], -1);

      // Reset during BUSY cycle 2 of a store to 1040 must drop the store.
      bus.MEM_W_EN   = 1'b1;
      bus.ALU_result = 32'd1040;
      bus.Val_Rm     = 32'hCAFEF00D;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n        = 1'b0;
      bus.MEM_W_EN = 1'b0;
      #1;
      check("midrst mrv",   bus.Mem_read_value, 32'd0);
      check("midrst ready", {31'd0, bus.ready}, 32'd0);
      check("midrst stall", {31'd0, bus.stall}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("midrst hold mrv", bus.Mem_read_value, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      $display("reset mid-write applied and released");
      @(negedge clk);
      check("post-rst ready", {31'd0, bus.ready}, 32'd0);
      @(posedge clk);
      #1;
      v.rd = 1; v.wr = 0; v.addr = 32'd1040; v.data = 32'h0;
      v.exp_mrv = 32'h0BADF00D; v.exp_err = 0;
      run_access(v, -1);

      // Flush: load dropped after cycle 1 still commits and pulses ready.
      v.rd = 1; v.wr = 0; v.addr = 32'd1032; v.data = 32'h0;
      v.exp_mrv = 32'hDEADBEEF; v.exp_err = 0;
      run_access(v, 1);
      @(negedge clk);
      check("post-flush ready", {31'd0, bus.ready}, 32'd0);
      check("post-flush mrv", bus.Mem_read_value, 32'hDEADBEEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected finish before 200000");
      $fatal(1, "timeout");
   end
endmodule
